// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, prediction-mode encodings and immediate helpers for the MIPS pipeline
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam int PRED_NT = 0;
  localparam int PRED_BTFN = 1;
  localparam int PRED_BHT = 2;
  function automatic logic [31:0] sext_shl2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/bht_ctr.sv
// bht_ctr: array of saturating counters with one async read port and one sync update port
module bht_ctr #(
  parameter int DEPTH = 64,
  parameter int CTR_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [CTR_BITS-1:0]      rd_ctr_o,
  input  logic                     upd_en_i,
  input  logic [$clog2(DEPTH)-1:0] upd_idx_i,
  input  logic                     upd_taken_i
);
  localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] MAX = '1;
  logic [CTR_BITS-1:0] ctr_q [DEPTH];
  logic [CTR_BITS-1:0] cur, nxt;
  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign cur = ctr_q[upd_idx_i];
  assign nxt = upd_taken_i ? (cur == MAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= INIT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= nxt;
    end
  end
endmodule

// File: rtl/fetch_bpred.sv
// fetch_bpred: IF stage owning the PC and IF/ID register, with selectable branch prediction
module fetch_bpred
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int PRED_MODE = PRED_BHT,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_BITS = 2,
  parameter logic [5:0] BR_OPCODE = OP_BEQ
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic        res_pred,
  input  logic [31:0] res_target,
  output logic        flush,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_pred
);
  localparam int IW = $clog2(BHT_DEPTH);
  logic [31:0] pc_q, pc_d, pc4, tgt, id_inst_q, id_pc4_q;
  logic id_valid_q, id_pred_q, is_br, pred, mispredict;
  logic [CTR_BITS-1:0] ctr;
  assign imem_addr = pc_q;
  assign pc4 = pc_q + 32'd4;
  assign is_br = imem_data[31:26] == BR_OPCODE;
  assign tgt = pc4 + sext_shl2(imem_data[15:0]);
  assign pred = is_br && (PRED_MODE == PRED_BTFN ? imem_data[15] :
                          PRED_MODE == PRED_BHT ? ctr[CTR_BITS-1] : 1'b0);
  assign mispredict = res_valid && (res_taken != res_pred);
  assign flush = mispredict && !rst;
  assign id_valid = id_valid_q;
  assign id_inst = id_inst_q;
  assign id_pc4 = id_pc4_q;
  assign id_pred = id_pred_q;
  always_comb begin
    pc_d = mispredict ? (res_taken ? res_target : res_pc + 32'd4) :
           stall ? pc_q :
           pred ? tgt : pc4;
  end
  // counters are only trained in dynamic mode; other modes keep them at reset value
  bht_ctr #(.DEPTH(BHT_DEPTH), .CTR_BITS(CTR_BITS)) u_bht (
    .clk(clk),
    .rst(rst),
    .rd_idx_i(pc_q[IW+1:2]),
    .rd_ctr_o(ctr),
    .upd_en_i(res_valid && PRED_MODE == PRED_BHT),
    .upd_idx_i(res_pc[IW+1:2]),
    .upd_taken_i(res_taken)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q <= '0;
      id_pc4_q <= '0;
      id_pred_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (mispredict) begin
        id_valid_q <= 1'b0;
        id_inst_q <= '0;
        id_pc4_q <= '0;
        id_pred_q <= 1'b0;
      end else if (!stall) begin
        id_valid_q <= 1'b1;
        id_inst_q <= imem_data;
        id_pc4_q <= pc4;
        id_pred_q <= pred;
      end
    end
  end
endmodule

// File: tb/tb_fetch_bpred.sv
// tb_fetch_bpred: scoreboard bench driving NT, BTFN and BHT instances with shared stimulus
module tb_fetch_bpred;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic res_valid = 1'b0;
  logic res_taken = 1'b0;
  logic res_pred = 1'b0;
  logic [31:0] res_pc = '0;
  logic [31:0] res_target = '0;
  logic [31:0] mem [64];
  logic [31:0] addr_w [3];
  logic [31:0] dat_w [3];
  logic [31:0] inst_w [3];
  logic [31:0] pc4_w [3];
  logic flush_w [3];
  logic vld_w [3];
  logic pred_w [3];

  typedef struct {
    int cy;
    bit [2:0] m;
    string n;
    bit ca;
    bit [31:0] a;
    bit f;
    bit ci;
    bit v;
    bit [31:0] p4;
    bit pr;
  } rec_t;
  rec_t q[$];
  rec_t mon_r;
  int cyc_n = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign dat_w[g] = mem[addr_w[g][7:2]];
    fetch_bpred #(.RESET_PC(32'h40), .PRED_MODE(g)) u_dut (
      .clk(clk),
      .rst(rst),
      .imem_addr(addr_w[g]),
      .imem_data(dat_w[g]),
      .stall(stall),
      .res_valid(res_valid),
      .res_pc(res_pc),
      .res_taken(res_taken),
      .res_pred(res_pred),
      .res_target(res_target),
      .flush(flush_w[g]),
      .id_valid(vld_w[g]),
      .id_inst(inst_w[g]),
      .id_pc4(pc4_w[g]),
      .id_pred(pred_w[g])
    );
  end

  task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s u%0d: got %h want %h", n, i, act, expv);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cy <= cyc_n) begin
      mon_r = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        if (mon_r.m[i]) begin
          if (mon_r.ca) chk({mon_r.n, ".addr"}, i, addr_w[i], mon_r.a);
          chk({mon_r.n, ".flush"}, i, 32'(flush_w[i]), 32'(mon_r.f));
          if (mon_r.ci) begin
            chk({mon_r.n, ".id_valid"}, i, 32'(vld_w[i]), 32'(mon_r.v));
            chk({mon_r.n, ".id_pred"}, i, 32'(pred_w[i]), 32'(mon_r.pr));
            if (mon_r.v) chk({mon_r.n, ".id_pc4"}, i, pc4_w[i], mon_r.p4);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc_n++;
    res_valid = 1'b0;
    stall = 1'b0;
  endtask

  task automatic expect_rec(input bit [2:0] m, input string n, input bit ca, input bit [31:0] a,
                            input bit f, input bit ci, input bit v, input bit [31:0] p4, input bit pr);
    rec_t r;
    r.cy = cyc_n; r.m = m; r.n = n; r.ca = ca; r.a = a;
    r.f = f; r.ci = ci; r.v = v; r.p4 = p4; r.pr = pr;
    q.push_back(r);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic pd, input logic [31:0] tg);
    res_valid = 1'b1;
    res_pc = pc;
    res_taken = tk;
    res_pred = pd;
    res_target = tg;
  endtask

  // redirect the BHT instance to the loop branch at 0x20 and observe its prediction
  task automatic fetch_loop(input string n, input bit pr);
    resolve(32'h100, 1'b1, 1'b0, 32'h20);
    expect_rec(3'b100, {n, ".redir"}, 0, 0, 1, 0, 0, 0, 0);
    tick;
    expect_rec(3'b100, {n, ".fetch"}, 1, 32'h20, 0, 1, 0, 0, 0);
    tick;
    expect_rec(3'b100, n, 1, pr ? 32'h14 : 32'h24, 0, 1, 1, 32'h24, pr);
    tick;
  endtask

  task automatic train(input string n, input logic tk);
    resolve(32'h20, tk, tk, 32'h14);
    expect_rec(3'b100, n, 0, 0, 0, 0, 0, 0, 0);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h1022_0003;
    mem[8] = 32'h1022_FFFC;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    expect_rec(3'b111, "rst0", 1, 32'h40, 0, 1, 0, 0, 0);
    tick;
    expect_rec(3'b111, "rst1", 1, 32'h44, 0, 1, 1, 32'h44, 0);
    tick;
    expect_rec(3'b111, "rst2", 1, 32'h48, 0, 1, 1, 32'h48, 0);
    tick;
    resolve(32'h100, 1'b1, 1'b0, 32'h4);
    expect_rec(3'b111, "redir4", 1, 32'h4C, 1, 0, 0, 0, 0);
    tick;
    expect_rec(3'b111, "at4", 1, 32'h4, 0, 1, 0, 0, 0);
    tick;
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      expect_rec(3'b111, "stall", 1, 32'h8, 0, 1, 1, 32'h8, 0);
      tick;
    end
    expect_rec(3'b111, "unstall", 1, 32'h8, 0, 1, 1, 32'h8, 0);
    tick;
    expect_rec(3'b111, "resume", 1, 32'hC, 0, 1, 1, 32'hC, 0);
    tick;
    expect_rec(3'b111, "beq_fetch", 1, 32'h10, 0, 1, 1, 32'h10, 0);
    tick;
    resolve(32'h10, 1'b1, 1'b0, 32'h20);
    expect_rec(3'b111, "m0_mis", 1, 32'h14, 1, 1, 1, 32'h14, 0);
    tick;
    expect_rec(3'b111, "m0_redir", 1, 32'h20, 0, 1, 0, 0, 0);
    tick;
    resolve(32'h20, 1'b0, 1'b1, 32'h14);
    expect_rec(3'b010, "m1_pred", 1, 32'h14, 1, 1, 1, 32'h24, 1);
    expect_rec(3'b001, "m0_nt", 1, 32'h24, 1, 1, 1, 32'h24, 0);
    expect_rec(3'b100, "m2_nt", 1, 32'h24, 1, 1, 1, 32'h24, 0);
    tick;
    expect_rec(3'b111, "m1_redir", 1, 32'h24, 0, 1, 0, 0, 0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    fetch_loop("bht_init", 0);
    train("t1", 1'b1);
    fetch_loop("bht_ctr2", 1);
    train("t2", 1'b1);
    train("t3", 1'b1);
    train("t4", 1'b1);
    fetch_loop("bht_sat", 1);
    train("n1", 1'b0);
    fetch_loop("bht_dn1", 1);
    train("n2", 1'b0);
    fetch_loop("bht_dn2", 0);
    resolve(32'h100, 1'b1, 1'b0, 32'h4);
    expect_rec(3'b111, "e_redir", 0, 0, 1, 0, 0, 0, 0);
    tick;
    expect_rec(3'b111, "e_at4", 1, 32'h4, 0, 1, 0, 0, 0);
    tick;
    stall = 1'b1;
    resolve(32'h100, 1'b1, 1'b0, 32'h30);
    expect_rec(3'b111, "stall_mis", 1, 32'h8, 1, 1, 1, 32'h8, 0);
    tick;
    expect_rec(3'b111, "stall_mis_clr", 1, 32'h30, 0, 1, 0, 0, 0);
    tick;
    train("pre_rst_t1", 1'b1);
    train("pre_rst_t2", 1'b1);
    rst = 1'b1;
    resolve(32'h20, 1'b1, 1'b0, 32'h60);
    expect_rec(3'b111, "rst_mis", 0, 0, 0, 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    expect_rec(3'b111, "rst_win", 1, 32'h40, 0, 1, 0, 0, 0);
    tick;
    fetch_loop("rst_reinit", 0);
    tick;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending records want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
